uart_prog_loader: RTL and testbench

//  Byte-stream program loader between the UART receiver and the instruction-fetch stage.

---
 rtl/uart_prog_loader.sv | 221 ++++++++++++++++++++++
 tb/tb_uart_prog_loader.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_prog_loader.sv
// Framed UART program loader: parses A5|seg|cnt|words|csum into 32-bit UPG writes
// for the instruction ROM (seg 0) and data RAM (seg 1).
module uart_prog_loader #(
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
    parameter int unsigned MAX_WORDS      = 16384
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        upg_rst_o,
    output logic        upg_wen_o,
    output logic [14:0] upg_adr_o,
    output logic [31:0] upg_dat_o,
    output logic        upg_done_o,
    output logic        busy_o,
    output logic [1:0]  err_o,
    output logic [14:0] wr_count_o
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [16:0] MAXW = 17'(MAX_WORDS);
    localparam logic [7:0] SYNC = 8'hA5;

    typedef enum logic [2:0] {
        S_IDLE, S_SEG, S_CNT_LO, S_CNT_HI, S_DATA, S_CSUM, S_DONE
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'b00,
        ERR_TIMEOUT = 2'b01,
        ERR_FRAME   = 2'b10,
        ERR_CSUM    = 2'b11
    } err_t;

    state_t        r_state, w_state;
    logic          r_seg, w_seg;
    logic [15:0]   r_cnt, w_cnt;
    logic [1:0]    r_lane, w_lane;
    logic [23:0]   r_word, w_word;
    logic [7:0]    r_csum, w_csum;
    logic [TW-1:0] r_tmo, w_tmo;
    logic          r_wen, w_wen;
    logic [14:0]   r_adr, w_adr;
    logic [31:0]   r_dat, w_dat;
    logic          r_rst, w_rst;
    logic          r_done, w_done;
    err_t          r_err, w_err;
    logic [14:0]   r_wr_count, w_wr_count;

    logic          w_active;
    logic          w_fail;
    err_t          w_fail_code;
    logic [15:0]   w_cnt_full;
    logic [14:0]   w_wr_inc;

    assign w_active = (r_state != S_IDLE) && (r_state != S_DONE);
    assign w_wr_inc = r_wr_count + 15'd1;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_seg      <= 1'b0;
            r_cnt      <= '0;
            r_lane     <= '0;
            r_word     <= '0;
            r_csum     <= '0;
            r_tmo      <= '0;
            r_wen      <= 1'b0;
            r_adr      <= '0;
            r_dat      <= '0;
            r_rst      <= 1'b1;
            r_done     <= 1'b0;
            r_err      <= ERR_NONE;
            r_wr_count <= '0;
        end else begin
            r_state    <= w_state;
            r_seg      <= w_seg;
            r_cnt      <= w_cnt;
            r_lane     <= w_lane;
            r_word     <= w_word;
            r_csum     <= w_csum;
            r_tmo      <= w_tmo;
            r_wen      <= w_wen;
            r_adr      <= w_adr;
            r_dat      <= w_dat;
            r_rst      <= w_rst;
            r_done     <= w_done;
            r_err      <= w_err;
            r_wr_count <= w_wr_count;
        end
    end

    always_comb begin
        w_state     = r_state;
        w_seg       = r_seg;
        w_cnt       = r_cnt;
        w_lane      = r_lane;
        w_word      = r_word;
        w_csum      = r_csum;
        w_wen       = 1'b0;
        w_adr       = r_adr;
        w_dat       = r_dat;
        w_rst       = r_rst;
        w_done      = r_done;
        w_err       = r_err;
        w_wr_count  = r_wr_count;
        w_fail      = 1'b0;
        w_fail_code = ERR_NONE;
        w_cnt_full  = {rx_data, r_cnt[7:0]};

        if (!w_active || rx_valid)
            w_tmo = '0;
        else
            w_tmo = r_tmo + TW'(1);

        case (r_state)
            S_IDLE, S_DONE: begin
                if (rx_valid && rx_data == SYNC) begin
                    w_state    = S_SEG;
                    w_rst      = 1'b0;
                    w_done     = 1'b0;
                    w_err      = ERR_NONE;
                    w_wr_count = '0;
                    w_csum     = '0;
                end
            end
            S_SEG: begin
                if (rx_valid) begin
                    w_csum = r_csum ^ rx_data;
                    if (rx_data <= 8'd1) begin
                        w_seg   = rx_data[0];
                        w_state = S_CNT_LO;
                    end else begin
                        w_fail      = 1'b1;
                        w_fail_code = ERR_FRAME;
                    end
                end
            end
            S_CNT_LO: begin
                if (rx_valid) begin
                    w_csum       = r_csum ^ rx_data;
                    w_cnt[7:0]   = rx_data;
                    w_state      = S_CNT_HI;
                end
            end
            S_CNT_HI: begin
                if (rx_valid) begin
                    w_csum = r_csum ^ rx_data;
                    w_cnt  = w_cnt_full;
                    w_lane = '0;
                    if ({1'b0, w_cnt_full} > MAXW) begin
                        w_fail      = 1'b1;
                        w_fail_code = ERR_FRAME;
                    end else if (w_cnt_full == 16'd0) begin
                        w_state = S_CSUM;
                    end else begin
                        w_state = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (rx_valid) begin
                    w_csum = r_csum ^ rx_data;
                    case (r_lane)
                        2'd0: w_word[7:0]   = rx_data;
                        2'd1: w_word[15:8]  = rx_data;
                        2'd2: w_word[23:16] = rx_data;
                        default: begin
                            // Strobe is registered, so it appears the cycle after the 4th byte
                            w_wen      = 1'b1;
                            w_adr      = {r_seg, r_wr_count[13:0]};
                            w_dat      = {rx_data, r_word};
                            w_wr_count = w_wr_inc;
                            if ({1'b0, w_wr_inc} == r_cnt)
                                w_state = S_CSUM;
                        end
                    endcase
                    w_lane = r_lane + 2'd1;
                end
            end
            S_CSUM: begin
                if (rx_valid) begin
                    if (rx_data == r_csum) begin
                        w_state = S_DONE;
                        w_done  = 1'b1;
                    end else begin
                        w_fail      = 1'b1;
                        w_fail_code = ERR_CSUM;
                    end
                end
            end
            default: w_state = S_IDLE;
        endcase

        // Timeout only fires on byte-less cycles, so it never collides with a byte error
        if (w_active && !rx_valid && r_tmo == TMO_LAST) begin
            w_fail      = 1'b1;
            w_fail_code = ERR_TIMEOUT;
        end

        if (w_fail) begin
            w_state = S_IDLE;
            w_err   = w_fail_code;
            w_rst   = 1'b1;
            w_done  = 1'b0;
            w_tmo   = '0;
        end
    end

    assign upg_rst_o  = r_rst;
    assign upg_wen_o  = r_wen;
    assign upg_adr_o  = r_adr;
    assign upg_dat_o  = r_dat;
    assign upg_done_o = r_done;
    assign busy_o     = w_active;
    assign err_o      = r_err;
    assign wr_count_o = r_wr_count;

endmodule

// File: tb/tb_uart_prog_loader.sv
// Bench for uart_prog_loader: directed frame table, randomized frames against a
// byte-list reference model, plus timeout and mid-frame reset sequences.
module tb_uart_prog_loader;

    localparam int TMO = 40;

    logic        clock = 1'b0;
    logic        reset;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        upg_rst_o;
    logic        upg_wen_o;
    logic [14:0] upg_adr_o;
    logic [31:0] upg_dat_o;
    logic        upg_done_o;
    logic        busy_o;
    logic [1:0]  err_o;
    logic [14:0] wr_count_o;

    always #5 clock = ~clock;

    uart_prog_loader #(.TIMEOUT_CYCLES(TMO), .MAX_WORDS(16384)) dut (
        .clock      (clock),
        .reset      (reset),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .upg_rst_o  (upg_rst_o),
        .upg_wen_o  (upg_wen_o),
        .upg_adr_o  (upg_adr_o),
        .upg_dat_o  (upg_dat_o),
        .upg_done_o (upg_done_o),
        .busy_o     (busy_o),
        .err_o      (err_o),
        .wr_count_o (wr_count_o)
    );

    int n_pass = 0;
    int n_chk  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Write monitor and CPU-mode invariant (never busy while CPU released)
    logic [46:0] cap_q[$];
    int          viol = 0;
    always @(negedge clock) begin
        if (upg_wen_o === 1'b1) cap_q.push_back({upg_adr_o, upg_dat_o});
        if (busy_o === 1'b1 && upg_rst_o === 1'b1) viol++;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        rx_valid = 1'b1;
        rx_data  = b;
        tick();
        rx_valid = 1'b0;
        repeat (gap) tick();
    endtask

    logic [7:0]  frm[$];
    logic [46:0] mdl_q[$];
    logic [1:0]  mdl_err;
    bit          mdl_done;
    int          mdl_wr;
    logic [14:0] exp_adr = '0;
    logic [31:0] exp_dat = '0;

    function automatic void build(input logic [7:0] seg, input int cnt, input logic [31:0] w0,
                                  input logic [31:0] step, input logic [7:0] corrupt, input bit rnd);
        logic [31:0] w;
        logic [7:0]  cs;
        logic [15:0] c16;
        frm.delete();
        frm.push_back(8'hA5);
        frm.push_back(seg);
        if (seg > 8'd1) return;
        c16 = 16'(cnt);
        frm.push_back(c16[7:0]);
        frm.push_back(c16[15:8]);
        if (cnt > 16384) return;
        for (int i = 0; i < cnt; i++) begin
            w = rnd ? 32'($urandom) : w0 + 32'(i) * step;
            for (int k = 0; k < 4; k++) frm.push_back(w[8*k +: 8]);
        end
        cs = '0;
        for (int i = 1; i < frm.size(); i++) cs ^= frm[i];
        frm.push_back(cs ^ corrupt);
    endfunction

    // Reference: interprets a complete frame byte list directly
    function automatic void model();
        int          cnt;
        logic [7:0]  cs;
        logic [13:0] wi;
        logic [31:0] word;
        mdl_q.delete();
        mdl_err  = 2'b00;
        mdl_done = 0;
        mdl_wr   = 0;
        if (frm[1] > 8'd1) begin mdl_err = 2'b10; return; end
        cnt = int'(frm[2]) + 256 * int'(frm[3]);
        if (cnt > 16384) begin mdl_err = 2'b10; return; end
        for (int w = 0; w < cnt; w++) begin
            wi   = 14'(w);
            word = {frm[4*w+7], frm[4*w+6], frm[4*w+5], frm[4*w+4]};
            mdl_q.push_back({frm[1][0], wi, word});
        end
        mdl_wr = cnt;
        cs = '0;
        for (int i = 1; i < frm.size() - 1; i++) cs ^= frm[i];
        if (frm[frm.size()-1] == cs) mdl_done = 1;
        else mdl_err = 2'b11;
    endfunction

    task automatic run_frame(input int gapmax, input string tag);
        int g;
        foreach (frm[i]) begin
            g = ($urandom_range(0, 15) == 0) ? TMO - 1 : $urandom_range(0, gapmax);
            send_byte(frm[i], g);
        end
        repeat (3) tick();
        model();
        chk({tag, ".nwr"}, 64'(cap_q.size()), 64'(mdl_q.size()));
        for (int i = 0; i < mdl_q.size(); i++)
            if (i < cap_q.size()) chk({tag, ".write"}, 64'(cap_q[i]), 64'(mdl_q[i]));
        if (mdl_q.size() > 0) {exp_adr, exp_dat} = mdl_q[mdl_q.size()-1];
        chk({tag, ".err"},  64'(err_o),      64'(mdl_err));
        chk({tag, ".done"}, 64'(upg_done_o), 64'(mdl_done));
        chk({tag, ".rst"},  64'(upg_rst_o),  64'(!mdl_done));
        chk({tag, ".wrc"},  64'(wr_count_o), 64'(mdl_wr));
        chk({tag, ".busy"}, 64'(busy_o),     64'(0));
        chk({tag, ".adr"},  64'(upg_adr_o),  64'(exp_adr));
        chk({tag, ".dat"},  64'(upg_dat_o),  64'(exp_dat));
        cap_q.delete();
    endtask

    typedef struct {
        logic [7:0]  seg;
        int          cnt;
        logic [31:0] w0;
        logic [31:0] step;
        logic [7:0]  corrupt;
        logic [1:0]  e_err;
        bit          e_done;
        int          e_wr;
        logic [14:0] e_adr;
        logic [31:0] e_dat;
    } vec_t;

    vec_t vecs[7];

    initial begin
        vecs[0] = '{8'h00, 2,      32'h44332211, 32'h44444444, 8'h00, 2'b00, 1, 2, 15'h0001, 32'h88776655};
        vecs[1] = '{8'h01, 2,      32'h44332211, 32'h44444444, 8'h00, 2'b00, 1, 2, 15'h4001, 32'h88776655};
        vecs[2] = '{8'h00, 0,      32'h0,        32'h0,        8'h00, 2'b00, 1, 0, 15'h4001, 32'h88776655};
        vecs[3] = '{8'h00, 3,      32'h01020304, 32'h10101010, 8'hFF, 2'b11, 0, 3, 15'h0002, 32'h21222324};
        vecs[4] = '{8'h02, 0,      32'h0,        32'h0,        8'h00, 2'b10, 0, 0, 15'h0002, 32'h21222324};
        vecs[5] = '{8'h00, 16'h4001, 32'h0,      32'h0,        8'h00, 2'b10, 0, 0, 15'h0002, 32'h21222324};
        vecs[6] = '{8'h01, 1,      32'hA5A5A5A5, 32'h0,        8'h00, 2'b00, 1, 1, 15'h4000, 32'hA5A5A5A5};

        reset = 1'b1; rx_valid = 1'b0; rx_data = '0;
        repeat (3) tick();
        reset = 1'b0;
        chk("rst.upg_rst", 64'(upg_rst_o), 64'(1));
        chk("rst.wen",     64'(upg_wen_o), 64'(0));
        chk("rst.adr",     64'(upg_adr_o), 64'(0));
        chk("rst.dat",     64'(upg_dat_o), 64'(0));
        chk("rst.done",    64'(upg_done_o), 64'(0));
        chk("rst.busy",    64'(busy_o), 64'(0));
        chk("rst.err",     64'(err_o), 64'(0));
        chk("rst.wrc",     64'(wr_count_o), 64'(0));

        for (int i = 0; i < 7; i++) begin
            build(vecs[i].seg, vecs[i].cnt, vecs[i].w0, vecs[i].step, vecs[i].corrupt, 0);
            foreach (frm[j]) send_byte(frm[j], i % 2);
            repeat (3) tick();
            model();
            chk("vec.nwr", 64'(cap_q.size()), 64'(vecs[i].e_wr));
            for (int j = 0; j < mdl_q.size(); j++)
                if (j < cap_q.size()) chk("vec.write", 64'(cap_q[j]), 64'(mdl_q[j]));
            chk("vec.err",  64'(err_o),      64'(vecs[i].e_err));
            chk("vec.done", 64'(upg_done_o), 64'(vecs[i].e_done));
            chk("vec.rst",  64'(upg_rst_o),  64'(!vecs[i].e_done));
            chk("vec.wrc",  64'(wr_count_o), 64'(vecs[i].e_wr));
            chk("vec.busy", 64'(busy_o),     64'(0));
            chk("vec.adr",  64'(upg_adr_o),  64'(vecs[i].e_adr));
            chk("vec.dat",  64'(upg_dat_o),  64'(vecs[i].e_dat));
            exp_adr = vecs[i].e_adr;
            exp_dat = vecs[i].e_dat;
            cap_q.delete();
        end

        for (int n = 0; n < 25; n++) begin
            logic [7:0] seg, cor, junk;
            int cnt;
            repeat ($urandom_range(0, 2)) begin
                junk = 8'($urandom_range(0, 255));
                if (junk == 8'hA5) junk = 8'h5A;
                send_byte(junk, $urandom_range(0, 2));
            end
            seg = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(2, 255)) : 8'($urandom_range(0, 1));
            cnt = ($urandom_range(0, 9) == 0) ? $urandom_range(16385, 65535) : $urandom_range(0, 5);
            cor = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
            build(seg, cnt, 32'h0, 32'h0, cor, 1);
            run_frame(3, "rnd");
        end

        // Timeout boundary: a byte arriving on the limit cycle wins
        send_byte(8'hA5, 0); send_byte(8'h00, 0); send_byte(8'h02, 0); send_byte(8'h00, 0);
        send_byte(8'h11, TMO - 1);
        send_byte(8'h22, 0);
        chk("tmo.byte_wins_err",  64'(err_o),  64'(0));
        chk("tmo.byte_wins_busy", 64'(busy_o), 64'(1));
        repeat (TMO - 1) tick();
        chk("tmo.pre_err",  64'(err_o),  64'(0));
        chk("tmo.pre_busy", 64'(busy_o), 64'(1));
        tick();
        chk("tmo.err",  64'(err_o),      64'(1));
        chk("tmo.busy", 64'(busy_o),     64'(0));
        chk("tmo.rst",  64'(upg_rst_o),  64'(1));
        chk("tmo.done", 64'(upg_done_o), 64'(0));
        chk("tmo.nwr",  64'(cap_q.size()), 64'(0));
        send_byte(8'hA5, 0);
        chk("resync.err",  64'(err_o),     64'(0));
        chk("resync.busy", 64'(busy_o),    64'(1));
        chk("resync.rst",  64'(upg_rst_o), 64'(0));

        // Reset coincides with the 4th data byte: the write must be suppressed
        send_byte(8'h01, 0); send_byte(8'h01, 0); send_byte(8'h00, 0);
        send_byte(8'hAA, 0); send_byte(8'hBB, 0); send_byte(8'hCC, 0);
        reset = 1'b1; rx_valid = 1'b1; rx_data = 8'hDD;
        tick();
        rx_valid = 1'b0; reset = 1'b0;
        chk("midrst.upg_rst", 64'(upg_rst_o), 64'(1));
        chk("midrst.wen",     64'(upg_wen_o), 64'(0));
        chk("midrst.adr",     64'(upg_adr_o), 64'(0));
        chk("midrst.dat",     64'(upg_dat_o), 64'(0));
        chk("midrst.done",    64'(upg_done_o), 64'(0));
        chk("midrst.busy",    64'(busy_o), 64'(0));
        chk("midrst.err",     64'(err_o), 64'(0));
        chk("midrst.wrc",     64'(wr_count_o), 64'(0));
        repeat (3) tick();
        chk("midrst.nwr", 64'(cap_q.size()), 64'(0));
        exp_adr = '0;
        exp_dat = '0;

        build(8'h00, 2, 32'h44332211, 32'h44444444, 8'h00, 0);
        run_frame(1, "post_rst");

        chk("mode_invariant", 64'(viol), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
